// File: rtl/spi3w_pkg.sv
// Shared types and constants for the 3-wire SPI responder.
package spi3w_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WDATA,
      RDATA,
      DONE
   } state_e;

   localparam logic CMD_READ  = 1'b1;
   localparam logic CMD_WRITE = 1'b0;

   localparam int unsigned A_WIDTH_DFLT   = 16;
   localparam int unsigned D_WIDTH_DFLT   = 8;
   localparam int unsigned MEM_DEPTH_DFLT = 16;

   // Frame length in sclk cycles: command bit + address + data.
   function automatic int unsigned frame_bits(input int unsigned aw, input int unsigned dw);
      return 1 + aw + dw;
   endfunction

   localparam int unsigned FRAME_BITS_DFLT = 1 + A_WIDTH_DFLT + D_WIDTH_DFLT;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with edge detection against a registered previous value.
module spi_sync_edge #(
   parameter logic rst_val = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Shift the pin value through the synchronizer and history flop.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Synchronizer registers; reset to the line's idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= rst_val;
         sync_q <= rst_val;
         prev_q <= rst_val;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q      = sync_q;
   assign rise_c = sync_q & ~prev_q;
   assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/spi3w_slave.sv
// 3-wire SPI responder with a small register file, fully in the clk domain.
module spi3w_slave
   import spi3w_pkg::*;
#(
   parameter int unsigned a_width   = A_WIDTH_DFLT,
   parameter int unsigned d_width   = D_WIDTH_DFLT,
   parameter int unsigned mem_depth = MEM_DEPTH_DFLT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sclk,
   input  logic               cs,
   input  logic               sdio_in,
   output logic               sdio_out,
   output logic               sdio_oe,
   output logic               wr_valid,
   output logic [a_width-1:0] wr_addr,
   output logic [d_width-1:0] wr_data,
   output logic               rd_valid,
   output logic               frame_err
);

   localparam int unsigned IDX_W      = (mem_depth > 1) ? $clog2(mem_depth) : 1;
   localparam int unsigned FRAME_BITS = frame_bits(a_width, d_width);
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic sdio_s, sdio_rise_unused, sdio_fall_unused;
   logic sclk_s_unused, cs_s_unused;

   spi_sync_edge #(.rst_val(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
   );

   spi_sync_edge #(.rst_val(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise_c(cs_rise), .fall_c(cs_fall)
   );

   // sdio passes through the same depth as sclk so a sample lines up with its rise.
   spi_sync_edge #(.rst_val(1'b0)) u_sync_sdio (
      .clk(clk), .rst(rst), .d(sdio_in), .q(sdio_s),
      .rise_c(sdio_rise_unused), .fall_c(sdio_fall_unused)
   );

   assign sclk_s_unused = sclk_s;
   assign cs_s_unused   = cs_s;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cmd_q, cmd_d;
   logic [a_width-1:0] addr_q, addr_d;
   logic [d_width-1:0] shift_q, shift_d;
   logic [d_width-1:0] mem_q [mem_depth];
   logic [d_width-1:0] mem_d [mem_depth];
   logic               sdio_out_q, sdio_out_d;
   logic               sdio_oe_q, sdio_oe_d;
   logic               wr_valid_q, wr_valid_d;
   logic [a_width-1:0] wr_addr_q, wr_addr_d;
   logic [d_width-1:0] wr_data_q, wr_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               frame_err_q, frame_err_d;

   logic [a_width-1:0] addr_next;
   logic [d_width-1:0] data_next;

   assign addr_next = {addr_q[a_width-2:0], sdio_s};
   assign data_next = {shift_q[d_width-2:0], sdio_s};

   // Frame decode; cnt counts sampled rises, then driven bits once in RDATA.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      shift_d     = shift_q;
      mem_d       = mem_q;
      sdio_out_d  = sdio_out_q;
      sdio_oe_d   = sdio_oe_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      if ((state_q != IDLE) && cs_rise) begin
         frame_err_d = (state_q != DONE);
         sdio_oe_d   = 1'b0;
         sdio_out_d  = 1'b0;
         state_d     = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  cnt_d   = '0;
                  state_d = CMD;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  cmd_d   = sdio_s;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = ADDR;
               end
            end
            ADDR: begin
               if (sclk_rise) begin
                  addr_d = addr_next;
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(a_width)) begin
                     case (cmd_q)
                        CMD_READ: begin
                           shift_d = mem_q[addr_next[IDX_W-1:0]];
                           cnt_d   = '0;
                           state_d = RDATA;
                        end
                        CMD_WRITE: state_d = WDATA;
                        default:   state_d = WDATA;
                     endcase
                  end
               end
            end
            WDATA: begin
               if (sclk_rise) begin
                  shift_d = data_next;
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                     mem_d[addr_q[IDX_W-1:0]] = data_next;
                     wr_addr_d  = addr_q;
                     wr_data_d  = data_next;
                     wr_valid_d = 1'b1;
                     state_d    = DONE;
                  end
               end
            end
            RDATA: begin
               if (sclk_fall) begin
                  if (cnt_q == CNT_W'(d_width)) begin
                     sdio_oe_d  = 1'b0;
                     sdio_out_d = 1'b0;
                     rd_valid_d = 1'b1;
                     state_d    = DONE;
                  end else begin
                     sdio_oe_d  = 1'b1;
                     sdio_out_d = shift_q[d_width-1];
                     shift_d    = {shift_q[d_width-2:0], 1'b0};
                     cnt_d      = cnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_q       <= 1'b0;
         addr_q      <= '0;
         shift_q     <= '0;
         mem_q       <= '{default: '0};
         sdio_out_q  <= 1'b0;
         sdio_oe_q   <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         shift_q     <= shift_d;
         mem_q       <= mem_d;
         sdio_out_q  <= sdio_out_d;
         sdio_oe_q   <= sdio_oe_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_valid_q  <= rd_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign sdio_out  = sdio_out_q;
   assign sdio_oe   = sdio_oe_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_valid  = rd_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/spi3w_slave.md
Name: spi3w_slave

Overview:
- 3-wire SPI responder (slave): the other end of the 3-wire SPI master link (sclk / cs / bidirectional sdio).
- Decodes read/write frames and holds an internal register file.
- On write frames, stores the data byte. On read frames, drives the stored byte back on sdio.
- Runs fully in the system clk domain: sclk and cs are oversampled, so the block needs no second clock.

Parameters:
- a_width, 16, address field width in the frame.
- d_width, 8, data field width in the frame.
- mem_depth, 16, register-file entries; indexed by the low clog2(mem_depth) address bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial clock from master; idle low (CPOL=0).
- cs  input  1  chip select, active low.
- sdio_in  input  1  sdio value seen at the pad.
- sdio_out  output  1  value the slave drives on sdio.
- sdio_oe  output  1  1 = slave drives sdio; the top level builds the tristate.
- wr_valid  output  1  one-clk pulse when a write frame commits.
- wr_addr  output  a_width  address of the last committed write.
- wr_data  output  d_width  data of the last committed write.
- rd_valid  output  1  one-clk pulse when a read frame has shifted its last data bit.
- frame_err  output  1  one-clk pulse when cs rises before a frame completes.

Behaviour:
- Reset:
  - sdio_out=0, sdio_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_valid=0, frame_err=0.
  - Register file cleared to 0; state=IDLE.
- Input conditioning:
  - sclk, cs and sdio_in each pass through a 2-flop synchronizer, then a registered edge detect.
  - An sclk/cs edge acts 3 clk cycles after it occurs at the pin.
  - Requirement: each sclk half-period is at least 4 clk cycles.
- Frame format, MSB first:
  - 1 command bit: 1 = read, 0 = write.
  - Then a_width address bits.
  - Then d_width data bits.
  - Total 25 sclk cycles at default parameters.
- Master drives sdio on sclk falling edges; the slave samples on sclk rising edges.
- State machine:
  - IDLE: sdio_oe=0. cs falling -> CMD; bit counter cleared.
  - CMD: sample 1 bit on sclk rise -> ADDR.
  - ADDR: shift a_width bits.
    - After the last address rise: write -> WDATA; read -> RDATA, with read shift register loaded from mem[addr idx].
  - WDATA: shift d_width bits.
    - On the last rise: mem[idx] <= data; wr_addr/wr_data updated; wr_valid pulses next clk -> DONE.
  - RDATA: on each sclk fall, sdio_oe=1 and sdio_out = next data bit, MSB first.
    - After the falling edge that follows the d_width-th read bit is sampled: sdio_oe=0, rd_valid pulses -> DONE.
  - DONE: ignore extra sclk edges; cs rising -> IDLE.
- cs rising in CMD/ADDR/WDATA/RDATA (abort):
  - frame_err pulse, sdio_oe=0 that same cycle, no memory write -> IDLE.
- cs rising in DONE: -> IDLE, no error.
- Write then read to the same address in consecutive frames returns the new data.
- No pipelining across frames: cs must rise between frames.
- Addresses whose upper bits differ but low index bits match alias to the same entry.
- sdio_oe is never 1 in IDLE, CMD, ADDR or WDATA. Bus contention with the master is impossible by construction.
- rst mid-frame: immediate return to reset values, including sdio_oe=0; the partial frame is discarded silently (no frame_err).

Decomposition:
- Shared package spi3w_pkg:
  - state enum (IDLE, CMD, ADDR, WDATA, RDATA, DONE);
  - CMD_READ=1 and CMD_WRITE=0;
  - frame length constants derived from a_width/d_width.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs; instantiated for sclk and cs, with sync-only use for sdio_in.

Test Plan:
- Write frame 0, addr 0xfffe, data 0xfe -> wr_valid pulse once, wr_addr=0xfffe, wr_data=0xfe; sdio_oe stays 0 for the whole frame.
- Read frame 1, addr 0xfffe after the previous step -> slave drives 1,1,1,1,1,1,1,0 on the 8 data cycles; rd_valid pulses; sdio_oe drops after the last bit.
- Writes 0xfd@0xfffd and 0xfc@0xfffc, then reads of 0xfffd, 0xfffc, 0xfffe -> returns 0xfd, 0xfc, 0xfe (no cross-entry corruption).
- Write 0xaa@0x0003, cs raised after 12 address bits -> frame_err pulse, no wr_valid; a following read of 0x0003 returns 0x00.
- Read of an unwritten address 0x0007 after reset -> 0x00 shifted out; 3 extra sclk pulses before cs rise are ignored, no frame_err.
- rst asserted during RDATA with sdio_oe=1 -> sdio_oe=0 on the next clk; the next write/read frame works normally.
